// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
//   Bundles the fetch stage's instruction-memory port, the execute-stage
//   redirect input and the decode valid/ready handshake.
//
//   master : the fetch stage (drives imem request and decode-side outputs)
//   slave  : the environment (memory, execute, decode)
//
//   imem_en / imem_addr   read request, word address
//   imem_rdata            read data, valid the cycle after imem_en
//   redirect_valid / _pc  one-cycle redirect pulse and target PC
//   inst_valid / _ready   decode handshake
//   instruction / inst_pc head word and its PC
// -----------------------------------------------------------------------------
interface instruction_fetch_if #(
    parameter int IMEM_ADDR_WIDTH = 14
);
    logic                       imem_en;
    logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]                imem_rdata;
    logic                       redirect_valid;
    logic [31:0]                redirect_pc;
    logic                       inst_valid;
    logic                       inst_ready;
    logic [31:0]                instruction;
    logic [31:0]                inst_pc;

    modport master (
        output imem_en, imem_addr, inst_valid, instruction, inst_pc,
        input  imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_en, imem_addr, inst_valid, instruction, inst_pc,
        output imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage: owns the PC, issues reads to a 1-cycle synchronous
//   instruction memory and queues returned words for decode. A redirect
//   pulse flushes the queue, drops any returning read and restarts fetch
//   at the target.
//
//   Ports:
//     clk  - clock, all state on rising edge
//     rst  - synchronous active-high reset
//     bus  - instruction_fetch_if.master (imem port, redirect, decode handshake)
//
//   Parameters:
//     RESET_PC        - PC loaded on reset (4-byte aligned)
//     IMEM_ADDR_WIDTH - word-address width of instruction memory
//
//   Configuration macro:
//     IFETCH_DOUBLE_BUFFER_EN - defined: two-entry queue (1 instr/cycle);
//                               undefined: single entry (1 instr/2 cycles)
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          IMEM_ADDR_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    instruction_fetch_if.master  bus
);

`ifdef IFETCH_DOUBLE_BUFFER_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    logic [31:0]      fetch_pc_q,    fetch_pc_d;
    logic             inflight_q,    inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic             discard_q,     discard_d;
    logic [CNT_W-1:0] count_q,       count_d;
    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];

    logic             head_valid;
    logic             pop;
    logic             push;
    logic             issue;
    logic [2:0]       occ;
    logic [CNT_W-1:0] wr_idx;

    // Valid is forced low while reset is held so decode never sees stale
    // queue contents during the reset cycle.
    assign head_valid = !rst && (count_q != '0);
    assign pop        = head_valid && bus.inst_ready;

    // Slots committed after this cycle: queued + returning - leaving.
    assign occ   = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign issue = !rst && !bus.redirect_valid && (occ < 3'(DEPTH));

    // A returning read is kept only if it belongs to the current stream;
    // a redirect in the same cycle flushes it along with the queue.
    assign push   = inflight_q && !discard_q && !bus.redirect_valid;
    assign wr_idx = count_q - CNT_W'(pop);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        discard_d     = inflight_q ? 1'b0 : discard_q;
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
        ent_d         = ent_q;

        if (issue) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            inflight_pc_d = fetch_pc_q;
        end

        // Shift-register queue: head is always entry 0.
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                ent_d[i] = ent_q[i+1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push && wr_idx == CNT_W'(i)) begin
                ent_d[i].word = bus.imem_rdata;
                ent_d[i].pc   = inflight_pc_q;
            end
        end

        // Redirect wins over issue and push; a handshake in this cycle has
        // already been delivered, so only the remaining contents are dropped.
        if (bus.redirect_valid) begin
            count_d    = '0;
            fetch_pc_d = bus.redirect_pc & ~32'h3;
            discard_d  = inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC & ~32'h3;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            discard_q     <= 1'b0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
        end
    end

    // Payload needs no reset: it is only visible when count is non-zero.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign bus.imem_en     = issue;
    assign bus.imem_addr   = fetch_pc_q[IMEM_ADDR_WIDTH+1:2];
    assign bus.inst_valid  = head_valid;
    assign bus.instruction = head_valid ? ent_q[0].word : NOP;
    assign bus.inst_pc     = head_valid ? ent_q[0].pc   : 32'h0;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
`ifdef IFETCH_DOUBLE_BUFFER_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_fetch_if #(.IMEM_ADDR_WIDTH(14)) ba ();
    instruction_fetch_if #(.IMEM_ADDR_WIDTH(14)) bb ();

    instruction_fetch #(.RESET_PC(32'h0000_0100), .IMEM_ADDR_WIDTH(14)) dut_a (
        .clk(clk), .rst(rst), .bus(ba)
    );
    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .IMEM_ADDR_WIDTH(14)) dut_b (
        .clk(clk), .rst(rst), .bus(bb)
    );

    // Memory model: word[n] = n.
    always_ff @(posedge clk) begin
        if (ba.imem_en) ba.imem_rdata <= {18'b0, ba.imem_addr};
        if (bb.imem_en) bb.imem_rdata <= {18'b0, bb.imem_addr};
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] log_pc [$];
    logic [31:0] log_w  [$];
    int          log_cyc[$];
    logic [31:0] logb_pc[$];
    logic [31:0] logb_w [$];

    logic        s_en, s_valid;
    logic [13:0] s_addr;
    logic [31:0] s_inst, s_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    // Sample the current cycle at negedge, log handshakes, then advance to
    // just after the next rising edge so the caller can set new inputs.
    task automatic tick();
        @(negedge clk);
        s_en    = ba.imem_en;
        s_addr  = ba.imem_addr;
        s_valid = ba.inst_valid;
        s_inst  = ba.instruction;
        s_pc    = ba.inst_pc;
        if (!rst && ba.inst_valid && ba.inst_ready) begin
            log_pc.push_back(ba.inst_pc);
            log_w.push_back(ba.instruction);
            log_cyc.push_back(cyc);
        end
        if (!rst && bb.inst_valid && bb.inst_ready) begin
            logb_pc.push_back(bb.inst_pc);
            logb_w.push_back(bb.instruction);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_log(input int n, input int lim);
        int k = 0;
        while (log_pc.size() < n && k < lim) begin
            tick();
            k++;
        end
        chk("wait_log", 32'(log_pc.size() >= n), 32'd1);
    endtask

    initial begin
        int n;
        int k;
        rst               = 1'b1;
        ba.inst_ready     = 1'b1;
        ba.redirect_valid = 1'b0;
        ba.redirect_pc    = '0;
        bb.inst_ready     = 1'b1;
        bb.redirect_valid = 1'b0;
        bb.redirect_pc    = '0;
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("rst_en",    32'(s_en),    32'd0);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_inst",  s_inst,       32'h13);
        chk("rst_pc",    s_pc,         32'h0);

        // Reset release and steady stream.
        rst = 1'b0;
        cyc = 0;
        tick();
        chk("c0_en",   32'(s_en),   32'd1);
        chk("c0_addr", 32'(s_addr), 32'h40);
        tick();
        tick();
        chk("c2_valid", 32'(s_valid), 32'd1);
        chk("c2_pc",    s_pc,         32'h100);
        chk("c2_inst",  s_inst,       32'h40);
        wait_log(3, 20);
        chk("first_cyc", 32'(log_cyc[0]), 32'd2);
        for (int i = 0; i < 3; i++) begin
            chk("seq_pc", log_pc[i], 32'h100 + 32'(4 * i));
            chk("seq_w",  log_w[i],  32'h40 + 32'(i));
        end
        for (int i = 0; i < 2; i++)
            chk("gap", 32'(log_cyc[i+1] - log_cyc[i]), (DEPTH == 2) ? 32'd1 : 32'd2);

        // PC wrap and address truncation on the second instance.
        chk("b_cnt", 32'(logb_pc.size() >= 3), 32'd1);
        chk("wrap_pc0", logb_pc[0], 32'hFFFF_FFF8);
        chk("wrap_pc1", logb_pc[1], 32'hFFFF_FFFC);
        chk("wrap_pc2", logb_pc[2], 32'h0000_0000);
        chk("wrap_w0",  logb_w[0],  32'h3FFE);
        chk("wrap_w1",  logb_w[1],  32'h3FFF);
        chk("wrap_w2",  logb_w[2],  32'h0);

        // Backpressure.
        ba.inst_ready = 1'b0;
        repeat (10) tick();
        chk("bp_en",    32'(s_en),    32'd0);
        chk("bp_valid", 32'(s_valid), 32'd1);
        chk("bp_pc",    s_pc,         32'h10C);
        chk("bp_inst",  s_inst,       32'h43);
        chk("bp_cnt",   32'(log_pc.size()), 32'd3);
        ba.inst_ready = 1'b1;
        wait_log(7, 30);
        for (int i = 3; i < 7; i++) begin
            chk("bp_seq_pc", log_pc[i], 32'h100 + 32'(4 * i));
            chk("bp_seq_w",  log_w[i],  32'h40 + 32'(i));
        end

        // Redirect with queue full and a read in flight.
        ba.inst_ready = 1'b0;
        repeat (5) tick();
        ba.inst_ready = 1'b1;
        tick();
        ba.inst_ready     = 1'b0;
        ba.redirect_valid = 1'b1;
        ba.redirect_pc    = 32'h2002;
        tick();
        chk("rd_t_en", 32'(s_en), 32'd0);
        ba.redirect_valid = 1'b0;
        tick();
        chk("rd_t1_en",    32'(s_en),    32'd1);
        chk("rd_t1_addr",  32'(s_addr),  32'h800);
        chk("rd_t1_valid", 32'(s_valid), 32'd0);
        tick();
        chk("rd_t2_valid", 32'(s_valid), 32'd0);
        tick();
        chk("rd_t3_valid", 32'(s_valid), 32'd1);
        chk("rd_t3_pc",    s_pc,         32'h2000);
        chk("rd_t3_inst",  s_inst,       32'h800);
        chk("rd_cnt",      32'(log_pc.size()), 32'd8);
        chk("rd_last_old", log_pc[7], 32'h11C);

        // Redirect coinciding with a handshake.
        ba.inst_ready = 1'b1;
        tick();
        k = 0;
        while (!ba.inst_valid && k < 10) begin
            tick();
            k++;
        end
        chk("hs_valid_seen", 32'(ba.inst_valid), 32'd1);
        ba.redirect_valid = 1'b1;
        ba.redirect_pc    = 32'h3000;
        tick();
        ba.redirect_valid = 1'b0;
        n = log_pc.size();
        wait_log(n + 1, 20);
        chk("hs_accept_pc", log_pc[n-1], 32'h2000 + 32'(4 * (n - 9)));
        chk("hs_next_pc",   log_pc[n],   32'h3000);
        chk("hs_next_w",    log_w[n],    32'hC00);

        // Reset mid-stream for one cycle.
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("mr_valid", 32'(s_valid), 32'd0);
        chk("mr_en",    32'(s_en),    32'd1);
        chk("mr_addr",  32'(s_addr),  32'h40);
        n = log_pc.size();
        wait_log(n + 1, 20);
        chk("mr_pc", log_pc[n], 32'h100);
        chk("mr_w",  log_w[n],  32'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
